// File: rtl/mem_ctrl.sv
// mem_ctrl: one-at-a-time load/store sequencer for the word-addressed ram, with
// address range checking and a bounded wait for the ram response.
module mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MEM_SIZE = 4096,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  input  logic              ram_response,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  assign cpu_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      ram_data  <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          if (cpu_addr >= ADDR_W'(MEM_SIZE)) begin
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            state    <= DONE;
          end else begin
            ram_data <= cpu_wdata;
            ram_addr <= cpu_addr;
            ram_wr   <= cpu_wr;
            state    <= SETTLE;
          end
        end
        // response may still be high from the previous access, so it is not looked at here
        SETTLE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (ram_response) begin
          if (!ram_wr) cpu_rdata <= ram_out;
          cpu_done <= 1'b1;
          state    <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cpu_done <= 1'b1;
          cpu_err  <= 1'b1;
          state    <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table, reset/busy corner sequences and randomized traffic
// against a transaction-level model of the controller and a behavioural ram.
module tb_mem_ctrl;
  localparam int TIMEOUT  = 16;
  localparam int MEM_SIZE = 4096;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, ram_data, ram_addr, ram_out;
  logic        ram_wr, ram_response;
  int          pass_n = 0, total_n = 0, dones = 0;
  always #5 clk = ~clk;
  mem_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_response(ram_response), .ram_out(ram_out)
  );
  always @(posedge clk) if (cpu_done) dones++;
  // behavioural ram: runs the op on its inputs every cycle; after an input change it
  // holds response low for lat cycles; stall keeps response low
  logic [31:0] ram_mem [int];
  logic [64:0] last;
  int          wait_n, lat = 0;
  logic        stall = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      ram_response <= 1'b0;
      ram_out      <= '0;
      last         = '0;
      wait_n       = 0;
    end else begin
      if ({ram_wr, ram_addr, ram_data} != last) begin
        last   = {ram_wr, ram_addr, ram_data};
        wait_n = lat;
      end
      if (stall) ram_response <= 1'b0;
      else if (wait_n > 0) begin
        wait_n--;
        ram_response <= 1'b0;
      end else begin
        if (ram_wr) ram_mem[int'(ram_addr[11:0])] = ram_data;
        ram_out      <= ram_mem.exists(int'(ram_addr[11:0])) ? ram_mem[int'(ram_addr[11:0])] : '0;
        ram_response <= 1'b1;
      end
    end
  end
  // transaction-level reference model
  logic [31:0] ref_mem [logic [31:0]];
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0, m_rdata = '0;
  task automatic model_step(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int l, input logic st,
                            output int e_lat, output logic e_err, output logic [31:0] e_rd);
    if (addr >= 32'(MEM_SIZE)) begin
      e_lat = 1;
      e_err = 1'b1;
    end else begin
      e_lat = st ? TIMEOUT + 2 : ({wr, addr, wdata} != {m_wr, m_addr, m_data}) ? 3 + l : 3;
      e_err = st;
      {m_wr, m_addr, m_data} = {wr, addr, wdata};
      if (wr) ref_mem[addr] = wdata;
      else if (!st) m_rdata = ref_mem.exists(addr) ? ref_mem[addr] : '0;
    end
    e_rd = m_rdata;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else pass_n++;
  endtask
  task automatic do_txn(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int l, input logic st, input logic noise,
                        input int e_lat, input logic e_err, input logic [31:0] e_rd);
    int k = 0;
    int d0;
    while (!cpu_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " ready"}, 32'(cpu_ready), 32'd1);
    d0 = dones;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; lat = l; stall = st;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk({nm, " ram_addr"}, ram_addr, m_addr);
        chk({nm, " ram_wr"}, 32'(ram_wr), 32'(m_wr));
        chk({nm, " ram_data"}, ram_data, m_data);
      end
      cpu_req  = noise && k < e_lat - 1 && k[0];
      cpu_addr = addr ^ 32'h1;
      cpu_wr   = ~wr;
    end while (!cpu_done && k < 60);
    cpu_req = 1'b0;
    chk({nm, " latency"}, 32'(k), 32'(e_lat));
    chk({nm, " err"}, 32'(cpu_err), 32'(e_err));
    chk({nm, " rdata"}, cpu_rdata, e_rd);
    chk({nm, " ram_addr_done"}, ram_addr, m_addr);
    @(negedge clk);
    chk({nm, " pulse"}, 32'(cpu_done), 32'd0);
    chk({nm, " done_count"}, 32'(dones), 32'(d0 + 1));
  endtask
  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    int          l;
    logic        st;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl [8];
  initial begin
    int          e_lat, d0;
    logic        e_err, wr, st, noise, prev_st;
    logic [31:0] e_rd, addr, wdata;
    tbl[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 0, 1'b0, 3,  1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h10,       32'h0,        0, 1'b0, 3,  1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'h10,       32'h0,        0, 1'b0, 3,  1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'd4096,     32'h0,        0, 1'b0, 1,  1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'h0,        0, 1'b0, 1,  1'b1, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 32'd4095,     32'h12345678, 1, 1'b0, 4,  1'b0, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 32'd4095,     32'h0,        2, 1'b0, 5,  1'b0, 32'h12345678};
    tbl[7] = '{1'b0, 32'h10,       32'h0,        0, 1'b1, TIMEOUT + 2, 1'b1, 32'h12345678};
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(cpu_ready), 32'd1);
    chk("rst ram_wr", 32'(ram_wr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset done", 32'(cpu_done), 32'd0);
    chk("reset err", 32'(cpu_err), 32'd0);
    chk("reset rdata", cpu_rdata, 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset ram_data", ram_data, 32'd0);
    chk("reset ready", 32'(cpu_ready), 32'd1);
    foreach (tbl[i]) begin
      model_step(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].l, tbl[i].st, e_lat, e_err, e_rd);
      do_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].l, tbl[i].st,
             1'b0, tbl[i].e_lat, tbl[i].e_err, tbl[i].e_rd);
    end
    // reset asserted while a store sits in WAIT
    stall = 1'b1; lat = 0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_wait ram_wr before", 32'(ram_wr), 32'd1);
    d0 = dones;
    #2 rst = 1'b1;
    #1 chk("rst_wait ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_wait ram_addr", ram_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    {m_wr, m_addr, m_data, m_rdata} = '0;
    chk("rst_wait ready", 32'(cpu_ready), 32'd1);
    chk("rst_wait rdata", cpu_rdata, 32'd0);
    repeat (5) @(negedge clk);
    chk("rst_wait no done", 32'(dones), 32'(d0));
    // requests toggled while busy must be ignored
    model_step(1'b0, 32'h10, 32'h0, 0, 1'b0, e_lat, e_err, e_rd);
    do_txn("busy_toggle", 1'b0, 32'h10, 32'h0, 0, 1'b0, 1'b1, 3, 1'b0, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    chk("busy_toggle idle", 32'(cpu_ready), 32'd1);
    prev_st = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0 || n == 0) begin
        wr    = 1'($urandom_range(0, 1));
        wdata = $urandom;
        case ($urandom_range(0, 3))
          0: addr = 32'd4095;
          1: addr = 32'(MEM_SIZE) + 32'($urandom_range(0, 1000));
          2: addr = $urandom | 32'h8000_0000;
          default: addr = 32'($urandom_range(0, 15));
        endcase
      end
      st      = !prev_st && $urandom_range(0, 7) == 0;
      prev_st = st;
      noise   = 1'($urandom_range(0, 1));
      lat     = st ? 0 : $urandom_range(0, 3);
      model_step(wr, addr, wdata, lat, st, e_lat, e_err, e_rd);
      do_txn($sformatf("rand%0d", n), wr, addr, wdata, lat, st, noise, e_lat, e_err, e_rd);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
